// File: rtl/line_scan_winner.sv
// Sequential N x N noughts-and-crosses winner detector: snapshots the board on
// start, then tests one line per clock (rows, columns, main and anti diagonal).
module line_scan_winner #(
  parameter int N = 3,
  localparam int NL = 2*N+2,
  localparam int LW = $clog2(NL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*N*N-1:0]  board,
  output logic              busy,
  output logic              done,
  output logic              winner,
  output logic [1:0]        who,
  output logic [LW-1:0]     win_line,
  output logic              draw,
  output logic              err
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [LW-1:0] LAST = LW'(NL-1);

  state_t            state, state_nxt;
  logic [2*N*N-1:0]  snap;
  logic [LW-1:0]     k;
  logic [1:0]        cells [N];
  logic              line_win;
  logic              last_line;
  logic              any_empty;
  logic              any_invalid;

  // Map line index k onto the N cell positions it covers.
  always_comb begin : line_select
    int kk;
    int idx;
    kk  = int'(k);
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (kk < N)
        idx = kk*N + i;
      else if (kk < 2*N)
        idx = i*N + (kk - N);
      else if (kk == 2*N)
        idx = i*N + i;
      else
        idx = i*N + (N - 1 - i);
      cells[i] = snap[2*idx +: 2];
    end
  end

  always_comb begin
    line_win = (cells[0] == 2'b01) || (cells[0] == 2'b10);
    for (int i = 1; i < N; i++) begin
      if (cells[i] != cells[0])
        line_win = 1'b0;
    end
  end

  always_comb begin
    any_empty   = 1'b0;
    any_invalid = 1'b0;
    for (int i = 0; i < N*N; i++) begin
      if (snap[2*i +: 2] == 2'b00)
        any_empty = 1'b1;
      if (snap[2*i +: 2] == 2'b11)
        any_invalid = 1'b1;
    end
  end

  assign last_line = (k == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: if (line_win || last_line) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
  end

  // Results are cleared on an accepted start and otherwise held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      k        <= '0;
      done     <= 1'b0;
      winner   <= 1'b0;
      who      <= 2'b00;
      win_line <= '0;
      draw     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap     <= board;
            k        <= '0;
            winner   <= 1'b0;
            who      <= 2'b00;
            win_line <= '0;
            draw     <= 1'b0;
            err      <= 1'b0;
          end
        end
        SCAN: begin
          if (line_win) begin
            winner   <= 1'b1;
            who      <= cells[0];
            win_line <= k;
            draw     <= 1'b0;
            err      <= any_invalid;
            done     <= 1'b1;
          end else if (last_line) begin
            draw <= !any_empty && !any_invalid;
            err  <= any_invalid;
            done <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
